// File: rtl/wsp_pkg.sv
// Shared types and constants for the IEEE 1500 serial-port sequencer.
// WIR opcodes are shared by the sequencer, the test controller and the benches.
package wsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_DONE    = 3'd5
  } wsp_state_t;

  localparam int WSP_WIR_LEN = 3;

  localparam logic [2:0] WIR_WS_BYPASS  = 3'b000;
  localparam logic [2:0] WIR_WS_EXTEST  = 3'b001;
  localparam logic [2:0] WIR_WS_INTEST  = 3'b010;
  localparam logic [2:0] WIR_WS_PRELOAD = 3'b101;

  // Opcodes that place the boundary register between WSI and WSO; all others select WBY.
  function automatic logic wir_selects_wbr(input logic [2:0] op);
    return (op == WIR_WS_EXTEST) || (op == WIR_WS_INTEST) || (op == WIR_WS_PRELOAD);
  endfunction

endpackage

// File: rtl/wsp_bit_counter.sv
// Loadable down-counter tracking the remaining shift bits of one scan access.
// index counts up from 0 while the remaining count runs down to 1.
module wsp_bit_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] index,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] base_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      base_reg <= load_val;
      cnt_reg  <= load_val;
    end else if (dec && !zero) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign index = base_reg - cnt_reg;
  assign last  = (cnt_reg == CNT_W'(1));
  assign zero  = (cnt_reg == '0);

endmodule

// File: rtl/wsp_sequencer.sv
// IEEE 1500 serial-port sequencer: turns one WIR or DR scan request into a
// SelectWIR/CaptureWR/ShiftWR/UpdateWR sequence and collects the WSO bits.
module wsp_sequencer
  import wsp_pkg::*;
#(
  parameter int WIR_LEN = WSP_WIR_LEN,
  parameter int DR_MAX  = 32,
  parameter int CNT_W   = $clog2(DR_MAX + 1)
) (
  input  logic              WRCK,
  input  logic              WRSTN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_wir,
  input  logic [CNT_W-1:0]  req_len,
  input  logic [DR_MAX-1:0] req_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              SelectWIR,
  output logic              CaptureWR,
  output logic              ShiftWR,
  output logic              UpdateWR,
  output logic              wsi_out,
  input  logic              wso_in
);

  wsp_state_t        state_reg;
  wsp_state_t        state_next;
  logic              is_wir_reg;
  logic [DR_MAX-1:0] data_reg;
  logic [DR_MAX-1:0] rsp_data_reg;
  logic              ready_reg;
  logic              rsp_valid_reg;
  logic              select_reg;
  logic              capture_reg;
  logic              shift_reg;
  logic              update_reg;
  logic              wsi_reg;

  logic              accept;
  logic [CNT_W-1:0]  eff_len;
  logic [CNT_W-1:0]  bit_index;
  logic              bit_last;
  logic              bit_zero;
  logic              select_src;
  logic              in_frame_next;

  assign accept = req_valid && (state_reg == ST_IDLE);

  always_comb begin
    eff_len = req_len;
    if (req_is_wir) begin
      eff_len = CNT_W'(WIR_LEN);
    end else if (req_len > CNT_W'(DR_MAX)) begin
      eff_len = CNT_W'(DR_MAX);
    end
  end

  wsp_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (WRCK),
    .rst_n    (WRSTN),
    .load     (accept),
    .load_val (eff_len),
    .dec      (state_reg == ST_SHIFT),
    .index    (bit_index),
    .last     (bit_last),
    .zero     (bit_zero)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (accept) state_next = ST_SETUP;
      ST_SETUP:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = bit_zero ? ST_UPDATE : ST_SHIFT;
      ST_SHIFT:   if (bit_last) state_next = ST_UPDATE;
      ST_UPDATE:  state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so every wrapper control is a clean flop.
  assign select_src    = accept ? req_is_wir : is_wir_reg;
  assign in_frame_next = (state_next == ST_SETUP) || (state_next == ST_CAPTURE) ||
                         (state_next == ST_SHIFT) || (state_next == ST_UPDATE);

  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      state_reg     <= ST_IDLE;
      is_wir_reg    <= 1'b0;
      data_reg      <= '0;
      rsp_data_reg  <= '0;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      select_reg    <= 1'b0;
      capture_reg   <= 1'b0;
      shift_reg     <= 1'b0;
      update_reg    <= 1'b0;
      wsi_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= (state_next == ST_IDLE);
      rsp_valid_reg <= (state_next == ST_DONE);
      select_reg    <= in_frame_next && select_src;
      capture_reg   <= (state_next == ST_CAPTURE);
      shift_reg     <= (state_next == ST_SHIFT);
      update_reg    <= (state_next == ST_UPDATE);
      wsi_reg       <= 1'b0;

      if (accept) begin
        is_wir_reg   <= req_is_wir;
        data_reg     <= req_data;
        rsp_data_reg <= '0;
      end else if (state_next == ST_SHIFT) begin
        // data_reg drains LSB-first so wsi_out is always the next bit to present.
        wsi_reg  <= data_reg[0];
        data_reg <= data_reg >> 1;
      end

      if (state_reg == ST_SHIFT) begin
        rsp_data_reg <= rsp_data_reg | (DR_MAX'(wso_in) << bit_index);
      end
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign SelectWIR = select_reg;
  assign CaptureWR = capture_reg;
  assign ShiftWR   = shift_reg;
  assign UpdateWR  = update_reg;
  assign wsi_out   = wsi_reg;

endmodule

// File: tb/tb_wsp_sequencer.sv
// Randomised bench for wsp_sequencer against a behavioural 1500 wrapper
// (WIR, WBY, WBR) and a chain-length reference model of the returned bits.
module tb_wsp_sequencer;
  import wsp_pkg::*;

  localparam int DR_MAX  = 32;
  localparam int CNT_W   = $clog2(DR_MAX + 1);
  localparam int WIR_LEN = 3;
  localparam int WBR_LEN = 12;

  logic              WRCK = 1'b0;
  logic              WRSTN = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_is_wir = 1'b0;
  logic [CNT_W-1:0]  req_len = '0;
  logic [DR_MAX-1:0] req_data = '0;
  logic              rsp_valid;
  logic [DR_MAX-1:0] rsp_data;
  logic              SelectWIR, CaptureWR, ShiftWR, UpdateWR;
  logic              wsi_out;
  logic              wso_in;

  always #5 WRCK = ~WRCK;

  wsp_sequencer #(
    .WIR_LEN (WIR_LEN),
    .DR_MAX  (DR_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .WRCK       (WRCK),
    .WRSTN      (WRSTN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_is_wir (req_is_wir),
    .req_len    (req_len),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .SelectWIR  (SelectWIR),
    .CaptureWR  (CaptureWR),
    .ShiftWR    (ShiftWR),
    .UpdateWR   (UpdateWR),
    .wsi_out    (wsi_out),
    .wso_in     (wso_in)
  );

  int vec_cnt = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Wrapper model
  logic [2:0]         wir, wir_sr;
  logic [WBR_LEN-1:0] wbr_sr;
  logic [WBR_LEN-1:0] wbr_cap = WBR_LEN'(12'hA5C);
  logic               wby;
  logic               wbr_sel;

  assign wbr_sel = wir_selects_wbr(wir);
  assign wso_in  = SelectWIR ? wir_sr[0] : (wbr_sel ? wbr_sr[0] : wby);

  always @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      wir    <= 3'b000;
      wir_sr <= 3'b000;
      wbr_sr <= '0;
      wby    <= 1'b0;
    end else begin
      if (CaptureWR) begin
        if (SelectWIR)    wir_sr <= wir;
        else if (wbr_sel) wbr_sr <= wbr_cap;
        else              wby    <= 1'b0;
      end
      if (ShiftWR) begin
        if (SelectWIR)    wir_sr <= {wsi_out, wir_sr[2:1]};
        else if (wbr_sel) wbr_sr <= {wsi_out, wbr_sr[WBR_LEN-1:1]};
        else              wby    <= wsi_out;
      end
      if (UpdateWR && SelectWIR) wir <= wir_sr;
    end
  end

  // Bits returned by a chain of n cells holding cap after shifting len bits of d.
  function automatic logic [31:0] ref_rsp(input int len, input int n,
                                          input logic [31:0] cap, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[k] = (k < n) ? cap[k] : d[k - n];
    return r;
  endfunction

  function automatic logic [31:0] len_mask(input int len);
    return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
  endfunction

  int cyc = 0;
  always @(posedge WRCK) cyc <= cyc + 1;

  // Transaction monitor, sampled on the falling edge
  bit          pend = 1'b0;
  bit          p_wir;
  int          p_t0, p_len, sel_cnt, shf_cnt, cap_cnt, upd_cnt;
  logic [31:0] p_data, p_exp, wsi_bits;
  int          n_acc = 0, n_rsp = 0, n_abort = 0, prot_err = 0;
  logic        prev_sel = 1'b0;

  initial begin
    int n;
    logic [31:0] cap;
    logic act;
    forever begin
      @(negedge WRCK);
      if (!WRSTN) begin
        if (pend) n_abort++;
        pend     = 1'b0;
        prev_sel = 1'b0;
      end else begin
        if (rsp_valid) begin
          n_rsp++;
          check("rsp_expected", pend, 1);
          if (pend) begin
            check("rsp_data", rsp_data, p_exp);
            check("latency", cyc - p_t0, p_len + 4);
            check("shift_cycles", shf_cnt, p_len);
            check("wsi_bits", wsi_bits, p_data & len_mask(p_len));
            check("selwir_cycles", sel_cnt, p_wir ? p_len + 3 : 0);
            check("capture_cycles", cap_cnt, 1);
            check("update_cycles", upd_cnt, 1);
            if (p_wir) check("wir_value", wir, p_data[2:0]);
            $display("txn %0d: wir=%0b len=%0d data=%08h rsp=%08h ref=%08h",
                     n_rsp, p_wir, p_len, p_data, rsp_data, p_exp);
          end
          pend = 1'b0;
        end
        if (pend) begin
          sel_cnt += int'(SelectWIR);
          cap_cnt += int'(CaptureWR);
          upd_cnt += int'(UpdateWR);
          if (ShiftWR) begin
            if (shf_cnt < 32) wsi_bits[shf_cnt] = wsi_out;
            shf_cnt++;
          end
        end
        if (req_valid && req_ready) begin
          check("accept_while_busy", pend, 0);
          n_acc++;
          p_wir  = req_is_wir;
          p_len  = req_is_wir ? WIR_LEN : ((int'(req_len) > DR_MAX) ? DR_MAX : int'(req_len));
          p_data = req_data;
          n      = req_is_wir ? WIR_LEN : (wbr_sel ? WBR_LEN : 1);
          cap    = req_is_wir ? 32'(wir) : (wbr_sel ? 32'(wbr_cap) : 32'd0);
          p_exp  = ref_rsp(p_len, n, cap, req_data);
          p_t0   = cyc;
          sel_cnt = 0; shf_cnt = 0; cap_cnt = 0; upd_cnt = 0;
          wsi_bits = '0;
          pend = 1'b1;
        end
        act = CaptureWR | ShiftWR | UpdateWR;
        if (int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR) > 1) prot_err++;
        if (wsi_out && !ShiftWR) prot_err++;
        if (req_ready && (SelectWIR || act || rsp_valid)) prot_err++;
        if ((SelectWIR != prev_sel) && act) prot_err++;
        prev_sel = SelectWIR;
      end
    end
  end

  task automatic send(input bit is_wir, input int len, input logic [31:0] data, input bit hold);
    int budget;
    @(posedge WRCK); #2;
    req_is_wir = is_wir;
    req_len    = CNT_W'(len);
    req_data   = data;
    req_valid  = 1'b1;
    budget = 200;
    while (!req_ready && budget > 0) begin
      @(posedge WRCK); #2;
      budget--;
    end
    check("ready_wait", req_ready, 1);
    @(posedge WRCK); #2;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int budget;
    budget = 200;
    while (!rsp_valid && budget > 0) begin
      @(posedge WRCK); #2;
      budget--;
    end
    check("rsp_wait", rsp_valid, 1);
    @(posedge WRCK); #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_outs"}, {SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi_out, rsp_valid}, 0);
    check({tag, "_rsp"}, rsp_data, 0);
  endtask

  initial begin
    int budget;
    int kind;
    WRSTN = 1'b0;
    repeat (3) @(posedge WRCK);
    #2;
    check_idle_outputs("reset_held");
    WRSTN = 1'b1;
    @(posedge WRCK); #2;
    check_idle_outputs("reset_released");

    // WIR load 101 from a cleared WIR, then back to bypass
    send(1'b1, 0, 32'b101, 1'b0);
    wait_rsp();
    check("wir_load_101", wir, 3'b101);
    check("wir_load_rsp", rsp_data, 0);
    send(1'b1, 0, 32'(WIR_WS_BYPASS), 1'b0);
    wait_rsp();

    // Bypass access of 4 bits
    send(1'b0, 4, 32'b1011, 1'b0);
    wait_rsp();
    check("bypass_rsp", rsp_data, 32'b0110);

    // Zero-length and over-length DR accesses
    send(1'b0, 0, $urandom, 1'b0);
    wait_rsp();
    send(1'b1, 0, 32'(WIR_WS_PRELOAD), 1'b0);
    wait_rsp();
    send(1'b0, 40, $urandom, 1'b0);
    wait_rsp();

    // Reset during shift cycle 5 of a 16-bit access
    send(1'b0, 16, $urandom, 1'b0);
    budget = 50;
    while (!ShiftWR && budget > 0) begin
      @(posedge WRCK); #2;
      budget--;
    end
    check("shift_start", ShiftWR, 1);
    repeat (5) @(posedge WRCK);
    #3;
    WRSTN = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    repeat (2) @(posedge WRCK);
    #2;
    WRSTN = 1'b1;
    send(1'b0, 8, $urandom, 1'b0);
    wait_rsp();

    // Back-to-back with req_valid held high
    send(1'b0, 5, $urandom, 1'b1);
    send(1'b0, 9, $urandom, 1'b0);
    wait_rsp();

    // Randomised mix of WIR loads and DR accesses
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) send(1'b1, 0, $urandom, 1'b0);
      else           send(1'b0, $urandom_range(0, 40), $urandom, 1'b0);
      wait_rsp();
      repeat ($urandom_range(0, 2)) @(posedge WRCK);
    end

    repeat (3) @(posedge WRCK);
    #2;
    check("rsp_pulses", n_rsp, n_acc - n_abort);
    check("protocol_errors", prot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
